mem_bank_rr: RTL
================

// Module: mem_bank_rr
// PURPOSE
//  Parametrised single-port memory bank shared by NUM_PORTS requesters via round-robin arbitration.
//  Adds valid/ready request handshake, byte write strobes and configurable read latency.
//  Every accepted request returns exactly one response pulse, write or read.
//  Sits behind the AXI slave front-ends as the shared storage of the memory environment.
// PARAMETERS
//  DATA_WIDTH  32    word width in bits; multiple of 8
//  DEPTH       1024  words; power of two; AW = $clog2(DEPTH)
//  NUM_PORTS   2     requester count, 1..8; PW = max(1,$clog2(NUM_PORTS))
//  RD_LATENCY  1     accept-to-response cycles, 1 or 2
// PORTS
//  ACLK       in   1                    clock, rising edge
//  ARESET     in   1                    synchronous reset, active-high
//  req_valid  in   NUM_PORTS            per-port request valid
//  req_ready  out  NUM_PORTS            per-port grant; handshake when valid&ready
//  req_we     in   NUM_PORTS            1=write, 0=read
//  req_addr   in   NUM_PORTS*AW         word address, port i at [i*AW +: AW]
//  req_wdata  in   NUM_PORTS*DATA_WIDTH write data, packed per port
//  req_wstrb  in   NUM_PORTS*DATA_WIDTH/8  byte enables, packed per port
//  rsp_valid  out  NUM_PORTS            one-cycle response pulse to the owning port
//  rsp_rdata  out  DATA_WIDTH           read data, shared; 0 for write responses
//  rsp_err    out  1                    parity error on this response (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rr pointer=0, pipeline cleared.
//    Memory array is not cleared. Responses in flight at reset are dropped.
//  - Arbitration: combinational, one grant per cycle. Search starts at rr pointer, wraps modulo NUM_PORTS.
//    req_ready[i]=1 only for the granted port with req_valid[i]=1; all-zero when no valid or in reset.
//  - Fairness: on a handshake, pointer <= granted+1 (wraps to 0). Otherwise the pointer holds.
//    No port waits more than NUM_PORTS-1 grants.
//  - Write: bytes with wstrb=1 are updated at the accept edge. wstrb=0 is a legal no-op that is still acked.
//  - Read: the array is read at the accept edge.
//    RD_LATENCY=2 adds one output register stage.
//  - Response: rsp_valid[port] pulses exactly RD_LATENCY cycles after the handshake edge. No backpressure.
//    Back-to-back accepts give back-to-back responses, in acceptance order.
//  - Ordering: a read accepted the cycle after a write to the same address returns the new data.
//  - Requester rule: a port holds valid, we, addr, wdata and wstrb stable until ready.
//    A port may deassert valid before ready; such a request is not counted.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//    - The array stores one even-parity bit per byte. Parity is written for strobed bytes only.
//    - Extra port par_inj (in, 1): when 1 on a write accept, the stored parity of the strobed bytes is inverted.
//    - On a read response, rsp_err=1 if any byte parity mismatches; rsp_rdata is still returned.
//  MEM_PARITY_EN undefined:
//    - No parity storage and no par_inj port; rsp_err tied 0.
// STRUCTURE
//  - Package mem_bank_pkg holds:
//    - rsp_stage_t struct {valid, port idx[PW], we}
//    - localparam STRB_W = DATA_WIDTH/8
//    - function onehot_to_idx
//  - Sub-module rr_arbiter #(N): inputs req[N], adv, clk, rst; output gnt[N] one-hot.
//    It owns the rotating pointer.
//  - Top level holds the array, strobe merge, response pipeline and optional parity logic.
// TESTING
//  1 Reset: assert ARESET 3 cycles with all req_valid=1.
//    -> req_ready=0, rsp_valid=0, rsp_rdata=0 throughout.
//  2 Port0 writes 0xDEADBEEF to addr 5, wstrb 0xF; then port0 writes 0x000000AA to addr 5, wstrb 0x1; then reads addr 5.
//    -> rsp_rdata=0xDEADBEAA RD_LATENCY cycles after the read accept.
//  3 Ports 0 and 1 both hold valid reads for 6 cycles.
//    -> grants alternate 0,1,0,1,0,1; each port receives 3 responses, in order.
//  4 Reset mid-flight: ARESET asserted the cycle after a read accept, with RD_LATENCY=2.
//    -> no rsp_valid for that read; pointer returns to 0.
//  5 MEM_PARITY_EN: write 0x12345678 to addr 7 with par_inj=1, then read addr 7.
//    -> rsp_rdata=0x12345678, rsp_err=1.
//    A clean write and read of addr 8 -> rsp_err=0.
//  6 NUM_PORTS=3, only port 2 valid after the pointer is at 0.
//    -> port 2 is granted in the same cycle; the pointer wraps to 0 afterwards.

Source files
------------

// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the round-robin memory bank.
package mem_bank_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned STRB_W       = DefDataWidth / 8;
  localparam int unsigned MaxPorts     = 8;
  localparam int unsigned IdxW         = 3;

  // One response pipeline slot; idx is sized for the largest supported port count.
  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
    logic            we;
  } rsp_stage_t;

  function automatic logic [IdxW-1:0] onehot_to_idx(input logic [MaxPorts-1:0] oh);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      if (oh[i]) idx = idx | IdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_bank_rr_if.sv
// Request/response bundle of mem_bank_rr: master side are the requesters, slave side the bank.
interface mem_bank_rr_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned NUM_PORTS  = 2
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*AW-1:0]         req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*StrbW-1:0]      req_wstrb;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_rdata;
  logic                            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_bank_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, rotating pointer advanced on handshake.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win;
  logic           found;
  logic [2*N-1:0] rot;

  always_comb begin
    // Doubling the request vector makes the wrap-around search a plain shift.
    rot   = {req_i, req_i} >> ptr_q;
    gnt_o = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + int'(k)) % int'(N));
      end
    end
    if (found && !rst_i) gnt_o[win] = 1'b1;

    ptr_d = ptr_q;
    if (adv_i) ptr_d = (32'(win) == N - 1) ? '0 : win + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_bank_rr.sv
// Single-port memory bank shared by NUM_PORTS round-robin requesters, one response per accept.
// Optional per-byte even parity with error injection when MEM_PARITY_EN is defined.
module mem_bank_rr
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic          ACLK,
  input logic          ARESET,
`ifdef MEM_PARITY_EN
  input logic          par_inj,
`endif
  mem_bank_rr_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]  gnt;
  logic [MaxPorts-1:0]   gnt_wide;
  logic [IdxW-1:0]       sel;
  logic [PW-1:0]         sel_p;
  logic                  hs;
  logic                  sel_we;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [StrbW-1:0]      sel_wstrb;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  rsp_stage_t            st1_q, st1_d, out_st;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d, out_rdata;
  logic                  err1_q, err1_d, out_err;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk_i (ACLK),
    .rst_i (ARESET),
    .req_i (bus.req_valid),
    .adv_i (hs),
    .gnt_o (gnt)
  );

  assign bus.req_ready = gnt;
  assign hs            = |gnt;

  always_comb begin
    gnt_wide                 = '0;
    gnt_wide[NUM_PORTS-1:0]  = gnt;
    sel                      = onehot_to_idx(gnt_wide);
    sel_p                    = sel[PW-1:0];
    sel_we                   = bus.req_we[sel_p];
    sel_addr                 = bus.req_addr[32'(sel_p)*AW +: AW];
    sel_wdata                = bus.req_wdata[32'(sel_p)*DATA_WIDTH +: DATA_WIDTH];
    sel_wstrb                = bus.req_wstrb[32'(sel_p)*StrbW +: StrbW];
    rd_word                  = mem_q[sel_addr];
  end

  // Array is deliberately not reset; only strobed bytes are touched.
  always_ff @(posedge ACLK) begin
    if (hs && sel_we) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (sel_wstrb[b]) mem_q[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [StrbW-1:0] par_q [DEPTH];
  logic [StrbW-1:0] rd_par_calc;

  always_ff @(posedge ACLK) begin
    if (hs && sel_we) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (sel_wstrb[b]) par_q[sel_addr][b] <= (^sel_wdata[b*8 +: 8]) ^ par_inj;
      end
    end
  end

  always_comb begin
    rd_par_calc = '0;
    for (int unsigned b = 0; b < StrbW; b++) rd_par_calc[b] = ^rd_word[b*8 +: 8];
    rd_err = |(rd_par_calc ^ par_q[sel_addr]);
  end
`else
  assign rd_err = 1'b0;
`endif

  always_comb begin
    st1_d       = '0;
    st1_d.valid = hs;
    st1_d.idx   = sel;
    st1_d.we    = sel_we;
    rdata1_d    = hs ? rd_word : '0;
    err1_d      = hs && rd_err;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      st1_q    <= '0;
      rdata1_q <= '0;
      err1_q   <= 1'b0;
    end else begin
      st1_q    <= st1_d;
      rdata1_q <= rdata1_d;
      err1_q   <= err1_d;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    rsp_stage_t            st2_q;
    logic [DATA_WIDTH-1:0] rdata2_q;
    logic                  err2_q;

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        st2_q    <= '0;
        rdata2_q <= '0;
        err2_q   <= 1'b0;
      end else begin
        st2_q    <= st1_q;
        rdata2_q <= rdata1_q;
        err2_q   <= err1_q;
      end
    end

    assign out_st    = st2_q;
    assign out_rdata = rdata2_q;
    assign out_err   = err2_q;
  end else begin : g_lat1
    assign out_st    = st1_q;
    assign out_rdata = rdata1_q;
    assign out_err   = err1_q;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (out_st.valid) bus.rsp_valid[out_st.idx[PW-1:0]] = 1'b1;
  end

  // Write responses carry no data and never flag parity.
  assign bus.rsp_rdata = out_st.we ? '0 : out_rdata;
  assign bus.rsp_err   = out_err && !out_st.we;

endmodule
